// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage family: the holding-state encoding
// and the bit value that idle stages drive on their payload outputs.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic BUBBLE_BIT = 1'b0;

  function automatic logic [1:0] occupancy_of(input state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: advances on inc and sticks at all-ones.
module pipe_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with optional skid entry, flush, occupancy report
// and a saturating back-pressure counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{BUBBLE_BIT}},
  parameter int               CW     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CW-1:0]    stall_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main, load_skid, main_from_skid;
  logic             accept, pop;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = occupancy_of(state_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: case ({accept, pop})
          2'b10:   begin state_d = FULL; load_skid = 1'b1; end
          2'b01:   state_d   = EMPTY;
          2'b11:   load_main = 1'b1;
          default: ;
        endcase
        FULL: if (pop) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: payload registers are reset here because the stage must come up with zeroed entries;
  // a plain datapath register that is never observed before being loaded would not need it.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready path; reset only masks it.
      logic ready_q;
      always_ff @(posedge clk) begin
        if (reset) ready_q <= 1'b1;
        else       ready_q <= (state_d != FULL);
      end
      assign in_ready = ready_q && !reset;
    end else begin : g_pass
      assign in_ready = (!out_valid || out_ready) && !reset;
    end
  endgenerate

  pipe_sat_cnt #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: three stage variants share one stimulus stream and are
// compared each cycle against a small FIFO-with-capacity reference model.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic [2:0]  rdy, ov;
  logic [31:0] od [3];
  logic [1:0]  occ [3];
  logic [15:0] sc_main, sc_pass;
  logic [3:0]  sc_sat;

  int vectors = 0;
  int miscompares = 0;
  bit known = 1'b0;

  // Reference model: per instance a FIFO holding up to two beats.
  int          m_cnt   [3];
  logic [31:0] m_buf   [3][2];
  int          m_stall [3];
  int          m_max   [3] = '{65535, 15, 65535};
  bit          m_skid  [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .SKID(1'b1), .CW(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[0]), .stall_cnt(sc_main));

  pipe_skid_stage #(.WIDTH(32), .SKID(1'b1), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[1]), .stall_cnt(sc_sat));

  pipe_skid_stage #(.WIDTH(32), .SKID(1'b0), .CW(16)) u_nsk (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[2]), .stall_cnt(sc_pass));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (reset)     return 1'b0;
    if (m_skid[i]) return m_cnt[i] < 2;
    return (m_cnt[i] == 0) || out_ready;
  endfunction

  task automatic check_all();
    logic [63:0] sc;
    for (int i = 0; i < 3; i++) begin
      sc = (i == 0) ? 64'(sc_main) : (i == 1) ? 64'(sc_sat) : 64'(sc_pass);
      check($sformatf("in_ready[%0d]", i),  64'(rdy[i]), 64'(exp_ready(i)));
      check($sformatf("out_valid[%0d]", i), 64'(ov[i]),  64'(m_cnt[i] > 0));
      check($sformatf("out_data[%0d]", i),  64'(od[i]),  (m_cnt[i] > 0) ? 64'(m_buf[i][0]) : 64'd0);
      check($sformatf("occupancy[%0d]", i), 64'(occ[i]), 64'(m_cnt[i]));
      check($sformatf("stall_cnt[%0d]", i), sc,          64'(m_stall[i]));
    end
  endtask

  task automatic model_step();
    logic acc, pop;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i]   = 0;
        m_stall[i] = 0;
      end else begin
        acc = in_valid && exp_ready(i);
        pop = (m_cnt[i] > 0) && out_ready;
        if ((m_cnt[i] > 0) && !out_ready && (m_stall[i] < m_max[i])) m_stall[i]++;
        if (flush) begin
          m_cnt[i] = 0;
        end else begin
          if (pop) begin
            m_buf[i][0] = m_buf[i][1];
            m_cnt[i]--;
          end
          if (acc) begin
            m_buf[i][m_cnt[i]] = in_data;
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, check 1 ns later, then advance the model at the rising edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic fl, input logic rst);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rst;
    #1;
    if (known) check_all();
    @(posedge clk);
    model_step();
    if (rst) known = 1'b1;
  endtask

  initial begin
    // Reset with a beat presented: it must never be accepted.
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("post_reset_in_ready", 64'(rdy[0]), 64'd1);
    check("post_reset_out_data", 64'(od[0]), 64'h0);

    // Streaming at full rate.
    cyc(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure fills the skid entry, then drains in order.
    cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    #2;
    check("bp_occupancy", 64'(occ[0]), 64'd2);
    check("bp_in_ready", 64'(rdy[0]), 64'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a beat offered on the same cycle.
    cyc(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFF, 1'b0, 1'b1, 1'b0);
    #2;
    check("flush_occupancy", 64'(occ[0]), 64'd0);
    check("flush_out_data", 64'(od[0]), 64'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Saturation of the 4-bit counter under a long stall.
    cyc(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("sat_stall_cnt", 64'(sc_sat), 64'd15);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("sat_stall_hold", 64'(sc_sat), 64'd15);

    // Toggle out_ready while the single-entry variant holds a beat.
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'hD0 + 32'(k), 1'(k % 2), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic including occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, minimum 1.
REQ-002 Parameter SKID, default 1: 1 selects a two-entry stage with registered in_ready; 0 selects a single-entry stage with combinational in_ready.
REQ-003 Parameter BUBBLE, default all-zero WIDTH bits: value driven on out_data whenever out_valid is 0.
REQ-004 Parameter CW, default 16: stall-counter width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_data  in  WIDTH  upstream payload.
REQ-009 in_ready  out  1  stage accepts a beat this cycle.
REQ-010 out_valid  out  1  downstream beat present.
REQ-011 out_data  out  WIDTH  downstream payload.
REQ-012 out_ready  in  1  downstream consumes a beat this cycle.
REQ-013 flush  in  1  discard all held beats, for branch or exception kill.
REQ-014 occupancy  out  2  number of held beats, 0 to 2.
REQ-015 stall_cnt  out  CW  saturating count of back-pressured cycles.

Function
REQ-016 Accept is in_valid AND in_ready; pop is out_valid AND out_ready.
REQ-017 States: EMPTY (occupancy 0), ONE (main entry only, occupancy 1), FULL (main and skid entries, occupancy 2); FULL is reachable only when SKID=1.
REQ-018 EMPTY: accept -> ONE with main <= in_data; otherwise stay EMPTY.
REQ-019 ONE: accept without pop -> FULL with skid <= in_data; pop without accept -> EMPTY; accept with pop -> ONE with main <= in_data; neither -> hold.
REQ-020 FULL: no accept; pop -> ONE with main <= skid; otherwise hold.
REQ-021 out_valid is 1 in ONE and FULL; out_data is main when out_valid is 1, else BUBBLE.
REQ-022 With SKID=1, in_ready is a register equal to 1 when the next state is not FULL, so it has no combinational path from out_ready.
REQ-023 With SKID=0, in_ready is (NOT out_valid) OR out_ready, combinational.
REQ-024 Latency: an accepted beat appears on out_data in the next cycle when the stage was EMPTY or popped; ordering is strictly FIFO.
REQ-025 Throughput is one beat per cycle in both modes while out_ready is held at 1.
REQ-026 flush has priority over accept and pop: the next state is EMPTY and any beat accepted in the same cycle is discarded.
REQ-027 A pop coincident with flush is still a valid transfer downstream.
REQ-028 in_ready is not gated by flush.
REQ-029 stall_cnt increments by 1 on each cycle with out_valid=1 and out_ready=0, saturates at 2^CW-1, and is not cleared by flush.
REQ-030 in_data is sampled only on accept; payload registers hold their value otherwise.

Reset
REQ-031 While reset=1 on a rising edge: state becomes EMPTY, main and skid are zero, and stall_cnt is 0.
REQ-032 reset has priority over flush and all handshakes.
REQ-033 in_ready is 0 while reset is high, in both modes.
REQ-034 With SKID=1, in_ready is 1 in the first cycle after reset deasserts.
REQ-035 During reset and until the first accept: out_valid=0, out_data=BUBBLE, occupancy=0.
REQ-036 A beat presented in the reset cycle is never accepted.

Structure
REQ-037 Shared package pipe_pkg holds the state enum (EMPTY, ONE, FULL) and the default BUBBLE constant used by all pipeline stages.
REQ-038 The saturating counter is a sub-module pipe_sat_cnt (parameter CW; inputs clk, reset, inc; output count).
REQ-039 Every other part of the block is inline in pipe_skid_stage.

Verification
REQ-040 Reset then idle, SKID=1, WIDTH=32, BUBBLE=0: after reset falls, in_ready=1, out_valid=0, out_data=0x00000000, occupancy=0, stall_cnt=0.
REQ-041 Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data is 0x11, 0x22, 0x33 on the next three cycles, occupancy never exceeds 1, in_ready stays 1.
REQ-042 Back-pressure, SKID=1: out_ready=0, push 0xA1 then 0xA2 -> occupancy=2 and in_ready=0 from the following cycle, stall_cnt counts up; raise out_ready -> 0xA1 then 0xA2 emerge in order.
REQ-043 Flush while FULL, with in_valid=1 carrying 0xFF on the same cycle -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, and 0xFF never emerges.
REQ-044 Saturation, CW=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt is 15 and stays at 15.
REQ-045 SKID=0: with out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle; occupancy never reaches 2.
